// File: rtl/mat_pkg.sv
// rtl/mat_pkg.sv - shared widths, FSM encoding and row-slice helper for the matrix row sequencer
package mat_pkg;

    localparam int ELEM_W = 8;
    localparam int N_ROWS = 5;
    localparam int N_COLS = 5;
    localparam int ROW_W  = 40;
    localparam int MAT_W  = 200;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_DRAIN = 2'd2;

    // LSB position of row r inside a packed matrix; row 0 sits at the top 40 bits
    function automatic logic [7:0] row_lsb(input logic [2:0] r);
        return 8'(MAT_W - ROW_W * (int'(r) + 1));
    endfunction

endpackage

// File: rtl/add_M.sv
// rtl/add_M.sv - registered row unit: five wrapping int8 adds plus signed-overflow flag
module add_M (
    input  logic        clk,
    input  logic        rst,
    input  logic [39:0] m1,
    input  logic [39:0] m2,
    output logic [39:0] m_out,
    output logic        ovf
);

    logic [39:0] sum_c;
    logic        ovf_c;

    // Element-wise wrapping sum; overflow when both operands share a sign the result lacks
    always_comb begin
        sum_c = '0;
        ovf_c = 1'b0;
        for (int i = 0; i < 5; i++) begin
            sum_c[8*i +: 8] = m1[8*i +: 8] + m2[8*i +: 8];
            ovf_c = ovf_c | ((m1[8*i+7] == m2[8*i+7]) && (sum_c[8*i+7] != m1[8*i+7]));
        end
    end

    // One register stage between sampled operands and result
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_out <= '0;
            ovf   <= 1'b0;
        end else begin
            m_out <= sum_c;
            ovf   <= ovf_c;
        end
    end

endmodule

// File: rtl/mat_tag_pipe.sv
// rtl/mat_tag_pipe.sv - fixed-depth shift register tracking {valid, row_idx} of rows in flight
module mat_tag_pipe #(
    parameter int DEPTH = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [2:0] in_idx,
    output logic       out_valid,
    output logic [2:0] out_idx
);

    logic [DEPTH-1:0] vld;
    logic [2:0]       idx [DEPTH];

    // Shift tags one stage per cycle; reset empties the pipe so in-flight results are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vld <= '0;
            for (int i = 0; i < DEPTH; i++) idx[i] <= 3'd0;
        end else begin
            vld[0] <= in_valid;
            idx[0] <= in_idx;
            for (int i = 1; i < DEPTH; i++) begin
                vld[i] <= vld[i-1];
                idx[i] <= idx[i-1];
            end
        end
    end

    assign out_valid = vld[DEPTH-1];
    assign out_idx   = idx[DEPTH-1];

endmodule

// File: rtl/mat_row_sequencer.sv
// rtl/mat_row_sequencer.sv - issues matrix row pairs to a row unit and reassembles the result matrix
module mat_row_sequencer
    import mat_pkg::*;
#(
    parameter int ROW_LAT = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [MAT_W-1:0]   mat_a,
    input  logic [MAT_W-1:0]   mat_b,
    output logic [ROW_W-1:0]   row_a,
    output logic [ROW_W-1:0]   row_b,
    output logic               row_valid,
    input  logic [ROW_W-1:0]   row_res,
    input  logic               row_ovf,
    output logic               busy,
    output logic               done,
    output logic [MAT_W-1:0]   mat_out,
    output logic [N_ROWS-1:0]  ovf_rows,
    output logic               ovf_any
);

    logic [1:0]        state;
    logic [2:0]        cnt;
    logic [MAT_W-1:0]  lat_a;
    logic [MAT_W-1:0]  lat_b;
    logic              issue;
    logic              tag_v;
    logic [2:0]        tag_idx;
    logic              cap_last;
    logic [N_ROWS-1:0] ovf_next;

    assign issue    = (state == ST_ISSUE);
    assign cap_last = tag_v && (tag_idx == 3'd4);

    // Tag leaves the pipe on exactly the edge its row result is valid at row_res
    mat_tag_pipe #(
        .DEPTH (ROW_LAT + 1)
    ) u_tag_pipe (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (issue),
        .in_idx    (cnt),
        .out_valid (tag_v),
        .out_idx   (tag_idx)
    );

    // Overflow vector including the row being captured this cycle, so ovf_any sees row 4
    always_comb begin
        ovf_next = ovf_rows;
        if (tag_v) ovf_next[tag_idx] = row_ovf;
    end

    // Control FSM, row issue, result capture and completion pulse
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_IDLE;
            cnt       <= 3'd0;
            lat_a     <= '0;
            lat_b     <= '0;
            row_a     <= '0;
            row_b     <= '0;
            row_valid <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
            mat_out   <= '0;
            ovf_rows  <= '0;
            ovf_any   <= 1'b0;
        end else begin
            done <= 1'b0;

            if (tag_v) begin
                mat_out[row_lsb(tag_idx) +: ROW_W] <= row_res;
                ovf_rows <= ovf_next;
            end
            if (cap_last) begin
                done    <= 1'b1;
                busy    <= 1'b0;
                ovf_any <= |ovf_next;
            end

            case (state)
                ST_IDLE: begin
                    if (start) begin
                        lat_a    <= mat_a;
                        lat_b    <= mat_b;
                        cnt      <= 3'd0;
                        ovf_rows <= '0;
                        busy     <= 1'b1;
                        state    <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    row_a     <= lat_a[row_lsb(cnt) +: ROW_W];
                    row_b     <= lat_b[row_lsb(cnt) +: ROW_W];
                    row_valid <= 1'b1;
                    cnt       <= cnt + 3'd1;
                    if (cnt == 3'd4) state <= ST_DRAIN;
                end
                ST_DRAIN: begin
                    row_valid <= 1'b0;
                    if (cap_last) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mat_row_sequencer.sv
// tb/tb_mat_row_sequencer.sv - directed self-checking bench for mat_row_sequencer with add_M row units
module tb_mat_row_sequencer;
    import mat_pkg::*;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         rst, start, start3;
    logic [199:0] mat_a, mat_b;

    logic [39:0]  row_a, row_b, row_res;
    logic         row_valid, row_ovf, busy, done, ovf_any;
    logic [199:0] mat_out;
    logic [4:0]   ovf_rows;

    logic [39:0]  row_a3, row_b3, add3_res, d1_res, d2_res;
    logic         row_valid3, add3_ovf, d1_ovf, d2_ovf, busy3, done3, ovf_any3;
    logic [199:0] mat_out3;
    logic [4:0]   ovf_rows3;

    int checks = 0;
    int errors = 0;

    localparam logic [199:0] T1_A   = {5{40'h0A141E2832}};
    localparam logic [199:0] T1_B   = {5{40'h050F19232D}};
    localparam logic [199:0] T1_EXP = {5{40'h0F23374B5F}};
    localparam logic [199:0] T2_A   = {40'h0AEC1ED832, 40'h0AEC1ED832, 40'h649C7F8032, 40'h0AEC1ED832, 40'h0AEC1ED832};
    localparam logic [199:0] T2_B   = {40'hFB0FE723D3, 40'hFB0FE723D3, 40'h1E1E01FF9C, 40'hFB0FE723D3, 40'hFB0FE723D3};
    localparam logic [199:0] T2_EXP = {40'h05FB05FB05, 40'h05FB05FB05, 40'h82BA807FCE, 40'h05FB05FB05, 40'h05FB05FB05};

    mat_row_sequencer dut (
        .clk(clk), .rst(rst), .start(start), .mat_a(mat_a), .mat_b(mat_b),
        .row_a(row_a), .row_b(row_b), .row_valid(row_valid),
        .row_res(row_res), .row_ovf(row_ovf),
        .busy(busy), .done(done), .mat_out(mat_out), .ovf_rows(ovf_rows), .ovf_any(ovf_any)
    );

    add_M u_add1 (.clk(clk), .rst(rst), .m1(row_a), .m2(row_b), .m_out(row_res), .ovf(row_ovf));

    mat_row_sequencer #(.ROW_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .mat_a(mat_a), .mat_b(mat_b),
        .row_a(row_a3), .row_b(row_b3), .row_valid(row_valid3),
        .row_res(d2_res), .row_ovf(d2_ovf),
        .busy(busy3), .done(done3), .mat_out(mat_out3), .ovf_rows(ovf_rows3), .ovf_any(ovf_any3)
    );

    add_M u_add3 (.clk(clk), .rst(rst), .m1(row_a3), .m2(row_b3), .m_out(add3_res), .ovf(add3_ovf));

    always @(posedge clk) begin
        d1_res <= add3_res;
        d1_ovf <= add3_ovf;
        d2_res <= d1_res;
        d2_ovf <= d1_ovf;
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Pulse start for one edge (E0) and count edges until done; stays bounded
    task automatic run_op(input bit use3, output int lat, output int rv_cycles,
                          output int early_writes, output logic busy_e0);
        if (use3) start3 = 1'b1; else start = 1'b1;
        tick;
        start = 1'b0;
        start3 = 1'b0;
        busy_e0 = use3 ? busy3 : busy;
        lat = -1;
        rv_cycles = 0;
        early_writes = 0;
        for (int n = 1; n <= 20; n++) begin
            tick;
            if (use3 ? row_valid3 : row_valid) rv_cycles++;
            if (use3 && n <= 4 && mat_out3 !== 200'd0) early_writes++;
            if (use3 ? done3 : done) begin
                lat = n;
                break;
            end
        end
    endtask

    task automatic test_reset;
        rst = 1'b0; start = 1'b0; start3 = 1'b0;
        mat_a = '0; mat_b = '0;
        tick; tick;
        checks++;
        if ({row_a, row_b, row_valid, busy, done, ovf_rows, ovf_any} !== '0) begin
            errors++;
            $display("FAIL reset_ctrl got %h want 0", {row_a, row_b, row_valid, busy, done, ovf_rows, ovf_any});
        end
        checks++;
        if (mat_out !== 200'd0) begin
            errors++;
            $display("FAIL reset_mat_out got %h want 0", mat_out);
        end
        rst = 1'b1;
        tick;
    endtask

    task automatic test_basic;
        int lat, rv, early;
        logic b0;
        mat_a = T1_A; mat_b = T1_B;
        run_op(1'b0, lat, rv, early, b0);
        checks++;
        if (b0 !== 1'b1) begin errors++; $display("FAIL basic_busy_e0 got %b want 1", b0); end
        checks++;
        if (lat != 7) begin errors++; $display("FAIL basic_latency got %0d want 7", lat); end
        checks++;
        if (rv != 5) begin errors++; $display("FAIL basic_row_valid_cycles got %0d want 5", rv); end
        checks++;
        if (mat_out !== T1_EXP) begin errors++; $display("FAIL basic_mat_out got %h want %h", mat_out, T1_EXP); end
        checks++;
        if ({ovf_rows, ovf_any, busy} !== 7'b0) begin
            errors++;
            $display("FAIL basic_flags got %b want 0000000", {ovf_rows, ovf_any, busy});
        end
        tick;
        checks++;
        if (done !== 1'b0) begin errors++; $display("FAIL basic_done_width got %b want 0", done); end
    endtask

    task automatic test_overflow;
        int lat, rv, early;
        logic b0;
        mat_a = T2_A; mat_b = T2_B;
        run_op(1'b0, lat, rv, early, b0);
        checks++;
        if (lat != 7) begin errors++; $display("FAIL ovf_latency got %0d want 7", lat); end
        checks++;
        if (mat_out !== T2_EXP) begin errors++; $display("FAIL ovf_mat_out got %h want %h", mat_out, T2_EXP); end
        checks++;
        if (ovf_rows !== 5'b00100) begin errors++; $display("FAIL ovf_rows got %b want 00100", ovf_rows); end
        checks++;
        if (ovf_any !== 1'b1) begin errors++; $display("FAIL ovf_any got %b want 1", ovf_any); end
        tick;
    endtask

    task automatic test_back_to_back;
        int ndone, first_done, second_done, busy_bad;
        mat_a = T1_A; mat_b = T1_B;
        ndone = 0; first_done = -1; second_done = -1; busy_bad = 0;
        start = 1'b1;
        for (int n = 0; n <= 24; n++) begin
            tick;
            if (n == 11) start = 1'b0;
            if (n <= 14 && busy !== (n != 7)) busy_bad++;
            if (done) begin
                ndone++;
                if (first_done < 0) first_done = n;
                else if (second_done < 0) second_done = n;
            end
        end
        checks++;
        if (ndone != 2) begin errors++; $display("FAIL b2b_done_count got %0d want 2", ndone); end
        checks++;
        if (first_done != 7 || second_done != 15) begin
            errors++;
            $display("FAIL b2b_done_edges got %0d,%0d want 7,15", first_done, second_done);
        end
        checks++;
        if (busy_bad != 0) begin errors++; $display("FAIL b2b_busy got %0d bad cycles want 0", busy_bad); end
        checks++;
        if (mat_out !== T1_EXP) begin errors++; $display("FAIL b2b_mat_out got %h want %h", mat_out, T1_EXP); end
    endtask

    task automatic test_operand_latch;
        int lat;
        mat_a = T2_A; mat_b = T2_B;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        mat_a = {200{1'b1}};
        lat = -1;
        for (int n = 2; n <= 20; n++) begin
            tick;
            if (done) begin lat = n; break; end
        end
        checks++;
        if (lat != 7) begin errors++; $display("FAIL latch_latency got %0d want 7", lat); end
        checks++;
        if (mat_out !== T2_EXP || ovf_rows !== 5'b00100) begin
            errors++;
            $display("FAIL latch_result got %h/%b want %h/00100", mat_out, ovf_rows, T2_EXP);
        end
        tick;
    endtask

    task automatic test_async_reset;
        int lat, rv, early, ndone;
        logic b0;
        mat_a = T1_A; mat_b = T1_B;
        start = 1'b1;
        tick;
        start = 1'b0;
        tick; tick;
        #4;
        rst = 1'b0;
        #1;
        checks++;
        if ({row_a, row_b, row_valid, busy, done, ovf_rows, ovf_any} !== '0) begin
            errors++;
            $display("FAIL arst_ctrl got %h want 0", {row_a, row_b, row_valid, busy, done, ovf_rows, ovf_any});
        end
        checks++;
        if (mat_out !== 200'd0) begin errors++; $display("FAIL arst_mat_out got %h want 0", mat_out); end
        tick; tick;
        rst = 1'b1;
        ndone = 0;
        for (int n = 0; n < 12; n++) begin
            tick;
            if (done || busy) ndone++;
        end
        checks++;
        if (ndone != 0) begin errors++; $display("FAIL arst_no_done got %0d active cycles want 0", ndone); end
        run_op(1'b0, lat, rv, early, b0);
        checks++;
        if (lat != 7 || mat_out !== T1_EXP) begin
            errors++;
            $display("FAIL arst_restart got lat %0d %h want lat 7 %h", lat, mat_out, T1_EXP);
        end
        tick;
    endtask

    task automatic test_row_lat3;
        int lat, rv, early;
        logic b0;
        mat_a = T1_A; mat_b = T1_B;
        run_op(1'b1, lat, rv, early, b0);
        checks++;
        if (lat != 9) begin errors++; $display("FAIL lat3_latency got %0d want 9", lat); end
        checks++;
        if (early != 0) begin errors++; $display("FAIL lat3_early_write got %0d want 0", early); end
        checks++;
        if (rv != 5) begin errors++; $display("FAIL lat3_row_valid_cycles got %0d want 5", rv); end
        checks++;
        if (mat_out3 !== T1_EXP || ovf_rows3 !== 5'b0 || ovf_any3 !== 1'b0) begin
            errors++;
            $display("FAIL lat3_result got %h/%b/%b want %h/00000/0", mat_out3, ovf_rows3, ovf_any3, T1_EXP);
        end
        tick;
    endtask

    initial begin
        test_reset;
        test_basic;
        test_overflow;
        test_back_to_back;
        test_operand_latch;
        test_async_reset;
        test_row_lat3;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
